// File: rtl/text_buffer_ctrl.sv
// text_buffer_ctrl: character buffer owner, serialises key events into single-cell writes behind display reads.
// Optional TEXT_WRAP_EN: printable at last cell and newline in last row wrap the cursor to cell 0.
module text_buffer_ctrl #(
  parameter int WIDTH_IN_CHARS = 16,
  parameter int HEIGHT_IN_CHARS = 6,
  parameter int MAX_CHARS = WIDTH_IN_CHARS * HEIGHT_IN_CHARS,
  parameter int ADDR_W = 8,
  parameter logic [7:0] TERM_CHAR = 8'h7C
) (
  input  logic              iVGA_CLK,
  input  logic              iRST,
  input  logic              key_valid,
  input  logic [7:0]        key_data,
  output logic              key_ready,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] cursor,
  output logic              busy,
  output logic              overflow
);
  localparam int IW = $clog2(MAX_CHARS);
  localparam logic [ADDR_W-1:0] L_MAXC = ADDR_W'(MAX_CHARS);
  localparam logic [ADDR_W-1:0] L_LAST = ADDR_W'(MAX_CHARS - 1);
  localparam logic [ADDR_W-1:0] L_ROW = ADDR_W'((HEIGHT_IN_CHARS - 1) * WIDTH_IN_CHARS);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WR_CHAR = 3'd1;
  localparam logic [2:0] S_BKSP = 3'd2;
  localparam logic [2:0] S_NEWLINE = 3'd3;
  localparam logic [2:0] S_CLEAR = 3'd4;
  localparam logic [2:0] S_WR_MARK = 3'd5;
  logic [7:0]        r_mem [MAX_CHARS];
  logic [2:0]        r_state, w_state_n;
  logic [ADDR_W-1:0] r_cursor, w_cursor_n, r_clr, w_clr_n, w_waddr, w_next_row;
  logic [7:0]        r_key, r_rd_data, w_wdata;
  logic              r_rd_valid, r_ovf, w_ovf_n, w_we, w_gnt, w_accept, w_printable, w_last, w_last_row;
  assign key_ready = (r_state == S_IDLE) && !iRST;
  assign busy = r_state != S_IDLE;
  assign cursor = r_cursor;
  assign rd_data = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign overflow = r_ovf;
  assign w_gnt = !rd_req;
  assign w_accept = key_valid && key_ready;
  assign w_printable = key_data >= 8'h20 && key_data <= 8'h7E && key_data != TERM_CHAR;
  assign w_last = r_cursor == L_LAST;
  assign w_last_row = r_cursor >= L_ROW;
  assign w_next_row = ADDR_W'((32'(r_cursor) / WIDTH_IN_CHARS + 1) * WIDTH_IN_CHARS);
  // Every state that writes does so only when the display is not reading this cycle.
  always_comb begin
    w_state_n = r_state;
    w_cursor_n = r_cursor;
    w_clr_n = r_clr;
    w_ovf_n = 1'b0;
    w_we = 1'b0;
    w_waddr = r_cursor;
    w_wdata = 8'h00;
    case (r_state)
      S_IDLE: if (w_accept) begin
        w_state_n = w_printable ? S_WR_CHAR : key_data == 8'h08 ? S_BKSP :
                    key_data == 8'h0D ? S_NEWLINE : key_data == 8'h0C ? S_CLEAR : S_IDLE;
        w_clr_n = key_data == 8'h0C ? '0 : r_clr;
      end
      S_WR_CHAR: if (w_gnt) begin
        w_we = 1'b1;
        w_wdata = r_key;
        w_state_n = S_WR_MARK;
        w_cursor_n = r_cursor + 1'b1;
        if (w_last) begin
`ifdef TEXT_WRAP_EN
          w_cursor_n = '0;
`else
          w_cursor_n = r_cursor;
          w_ovf_n = 1'b1;
          w_state_n = S_IDLE;
`endif
        end
      end
      S_BKSP: if (r_cursor == '0) w_state_n = S_IDLE;
      else if (w_gnt) begin
        w_we = 1'b1;
        w_cursor_n = r_cursor - 1'b1;
        w_state_n = S_WR_MARK;
      end
      S_NEWLINE: begin
`ifdef TEXT_WRAP_EN
        if (w_gnt) begin
          w_we = 1'b1;
          w_cursor_n = w_last_row ? '0 : w_next_row;
          w_state_n = S_WR_MARK;
        end
`else
        if (w_last_row) w_state_n = S_IDLE;
        else if (w_gnt) begin
          w_we = 1'b1;
          w_cursor_n = w_next_row;
          w_state_n = S_WR_MARK;
        end
`endif
      end
      S_CLEAR: if (w_gnt) begin
        w_we = 1'b1;
        w_waddr = r_clr;
        w_clr_n = r_clr + 1'b1;
        w_cursor_n = r_clr == L_LAST ? '0 : r_cursor;
        w_state_n = r_clr == L_LAST ? S_WR_MARK : S_CLEAR;
      end
      S_WR_MARK: if (w_gnt) begin
        w_we = 1'b1;
        w_wdata = TERM_CHAR;
        w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      r_state <= S_CLEAR;
      r_cursor <= '0;
      r_clr <= '0;
      r_rd_data <= 8'h00;
      r_rd_valid <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cursor <= w_cursor_n;
      r_clr <= w_clr_n;
      r_ovf <= w_ovf_n;
      r_rd_valid <= rd_req;
      if (rd_req) r_rd_data <= rd_addr < L_MAXC ? r_mem[rd_addr[IW-1:0]] : 8'h00;
    end
  end
  always_ff @(posedge iVGA_CLK) begin
    if (w_we && !iRST) r_mem[w_waddr[IW-1:0]] <= w_wdata;
    if (w_accept) r_key <= key_data;
  end
endmodule

// File: tb/tb_text_buffer_ctrl.sv
// tb_text_buffer_ctrl: vector table, corner sequences and random keys against a buffer/cursor model.
module tb_text_buffer_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_valid = 1'b0;
  logic [7:0] key_data = 8'h00;
  logic key_ready;
  logic rd_req = 1'b0;
  logic [7:0] rd_addr = 8'h00;
  logic [7:0] rd_data;
  logic rd_valid;
  logic [7:0] cursor;
  logic busy;
  logic overflow;
  int tests = 0;
  int fails = 0;
  logic [7:0] mem_m [96];
  int cur_m = 0;

  text_buffer_ctrl dut (
    .iVGA_CLK(clk), .iRST(rst), .key_valid(key_valid), .key_data(key_data), .key_ready(key_ready),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .cursor(cursor), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 96; i++) mem_m[i] = 8'h00;
    cur_m = 0;
    mem_m[0] = 8'h7C;
  endfunction

  function automatic int model_key(input logic [7:0] k);
    int ovf = 0;
    if (k >= 8'h20 && k <= 8'h7E && k != 8'h7C) begin
      mem_m[cur_m] = k;
      if (cur_m < 95) begin
        cur_m++;
        mem_m[cur_m] = 8'h7C;
      end else begin
`ifdef TEXT_WRAP_EN
        cur_m = 0;
        mem_m[0] = 8'h7C;
`else
        ovf = 1;
`endif
      end
    end else if (k == 8'h08) begin
      if (cur_m != 0) begin
        mem_m[cur_m] = 8'h00;
        cur_m--;
        mem_m[cur_m] = 8'h7C;
      end
    end else if (k == 8'h0D) begin
      if (cur_m < 80) begin
        mem_m[cur_m] = 8'h00;
        cur_m = (cur_m / 16 + 1) * 16;
        mem_m[cur_m] = 8'h7C;
      end else begin
`ifdef TEXT_WRAP_EN
        mem_m[cur_m] = 8'h00;
        cur_m = 0;
        mem_m[0] = 8'h7C;
`endif
      end
    end else if (k == 8'h0C) begin
      model_clear();
    end
    return ovf;
  endfunction

  task automatic send_key(input logic [7:0] k, input bit stall, output int lat, output int ovf);
    int w = 0;
    while (!key_ready && w < 1000) begin
      tick;
      w++;
    end
    if (!key_ready) chk("ready_timeout", 0, 1);
    key_valid = 1'b1;
    key_data = k;
    tick;
    key_valid = 1'b0;
    lat = 0;
    ovf = int'(overflow);
    while (busy && lat < 1000) begin
      if (stall) begin
        rd_req = 1'($urandom_range(0, 1));
        rd_addr = 8'($urandom_range(0, 127));
      end
      tick;
      lat++;
      ovf += int'(overflow);
    end
    rd_req = 1'b0;
    if (busy) chk("busy_timeout", 0, 1);
    tick;
    ovf += int'(overflow);
  endtask

  task automatic dump_check(input string name);
    int bad = 0;
    int first = -1;
    logic [7:0] got = 8'h00;
    rd_req = 1'b1;
    for (int a = 0; a < 96; a++) begin
      rd_addr = 8'(a);
      tick;
      if (!rd_valid || rd_data !== mem_m[a]) begin
        if (first < 0) begin
          first = a;
          got = rd_data;
        end
        bad++;
      end
    end
    rd_req = 1'b0;
    tick;
    if (bad != 0) $display("  %s: first bad cell %0d read %h model %h", name, first, got, mem_m[first]);
    chk(name, bad, 0);
  endtask

  typedef struct {
    logic [7:0] key;
    int cur;
    int lat;
    bit dump;
  } vec_t;

  initial begin
    vec_t tbl[12];
    int lat, ovf, eovf, n;
    logic [7:0] prev, k;
    tbl[0] = '{8'h41, 1, 2, 1'b0};
    tbl[1] = '{8'h62, 2, 2, 1'b1};
    tbl[2] = '{8'h08, 1, 2, 1'b1};
    tbl[3] = '{8'h08, 0, 2, 1'b0};
    tbl[4] = '{8'h08, 0, -1, 1'b1};
    tbl[5] = '{8'h78, 1, 2, 1'b0};
    tbl[6] = '{8'h79, 2, 2, 1'b0};
    tbl[7] = '{8'h7A, 3, 2, 1'b0};
    tbl[8] = '{8'h0D, 16, 2, 1'b1};
    tbl[9] = '{8'h01, 16, 0, 1'b0};
    tbl[10] = '{8'h7C, 16, 0, 1'b0};
    tbl[11] = '{8'h4B, 17, 2, 1'b1};

    tick;
    tick;
    chk("reset_key_ready", int'(key_ready), 0);
    chk("reset_busy", int'(busy), 1);
    chk("reset_cursor", int'(cursor), 0);
    chk("reset_rd_valid", int'(rd_valid), 0);
    chk("reset_rd_data", int'(rd_data), 0);
    chk("reset_overflow", int'(overflow), 0);
    rst = 1'b0;
    n = 0;
    while (!key_ready && n < 500) begin
      tick;
      n++;
    end
    chk("reset_clear_cycles", n, 97);
    model_clear();
    dump_check("reset_contents");

    foreach (tbl[i]) begin
      send_key(tbl[i].key, 1'b0, lat, ovf);
      eovf = model_key(tbl[i].key);
      chk($sformatf("vec%0d_cursor", i), int'(cursor), tbl[i].cur);
      chk($sformatf("vec%0d_model_cursor", i), int'(cursor), cur_m);
      chk($sformatf("vec%0d_overflow", i), ovf, eovf);
      if (tbl[i].lat >= 0) chk($sformatf("vec%0d_busy_cycles", i), lat, tbl[i].lat);
      if (tbl[i].dump) dump_check($sformatf("vec%0d_contents", i));
    end

    rd_req = 1'b1;
    rd_addr = 8'd17;
    key_valid = 1'b1;
    key_data = 8'h5A;
    tick;
    key_valid = 1'b0;
    n = 0;
    for (int c = 0; c < 9; c++) begin
      prev = rd_addr;
      if (rd_data !== (prev < 96 ? mem_m[prev] : 8'h00) || !rd_valid) n++;
      if (cursor !== 8'(cur_m) || !busy || key_ready) n++;
      rd_addr = 8'($urandom_range(0, 120));
      tick;
    end
    prev = rd_addr;
    if (rd_data !== (prev < 96 ? mem_m[prev] : 8'h00)) n++;
    chk("hold_reads_and_stall", n, 0);
    rd_req = 1'b0;
    lat = 0;
    while (busy && lat < 20) begin
      tick;
      lat++;
    end
    chk("hold_release_cycles", lat, 2);
    void'(model_key(8'h5A));
    chk("hold_cursor", int'(cursor), cur_m);
    tick;
    dump_check("hold_contents");

    send_key(8'h0C, 1'b0, lat, ovf);
    model_clear();
    chk("clear_cycles", lat, 97);
    for (int i = 0; i < 5; i++) begin
      send_key(8'h0D, 1'b0, lat, ovf);
      void'(model_key(8'h0D));
    end
    for (int i = 0; i < 5; i++) begin
      send_key(8'h30 + 8'(i), 1'b0, lat, ovf);
      void'(model_key(8'h30 + 8'(i)));
    end
    chk("lastrow_cursor", int'(cursor), 85);
    send_key(8'h0D, 1'b0, lat, ovf);
    void'(model_key(8'h0D));
    chk("lastrow_newline_cursor", int'(cursor), cur_m);
    dump_check("lastrow_contents");

    send_key(8'h0C, 1'b0, lat, ovf);
    model_clear();
    for (int i = 0; i < 95; i++) begin
      k = 8'h61 + 8'(i % 26);
      send_key(k, 1'b0, lat, ovf);
      void'(model_key(k));
    end
    chk("fill_cursor", int'(cursor), 95);
    send_key(8'h51, 1'b0, lat, ovf);
    eovf = model_key(8'h51);
    chk("last_cell_overflow", ovf, eovf);
    chk("last_cell_cursor", int'(cursor), cur_m);
    dump_check("last_cell_contents");

    for (int i = 0; i < 250; i++) begin
      n = $urandom_range(0, 99);
      k = n < 60 ? 8'($urandom_range(32, 126)) : n < 75 ? 8'h08 : n < 88 ? 8'h0D :
          n < 90 ? 8'h0C : 8'($urandom_range(0, 255));
      send_key(k, 1'($urandom_range(0, 1)), lat, ovf);
      eovf = model_key(k);
      chk("rand_cursor", int'(cursor), cur_m);
      chk("rand_overflow", ovf, eovf);
      if (i % 50 == 49) dump_check("rand_contents");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
